// File: rtl/mul_shift_add_ctrl_if.sv
// Operand/result handshake bundle for the shift-add multiplier controller.
// The master side drives operands and consumes the result; the slave side is the controller.
interface mul_shift_add_ctrl_if #(
  parameter int LEN = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [LEN-1:0]   in_a;
  logic [LEN-1:0]   in_b;
  logic             out_valid;
  logic             out_ready;
  logic [2*LEN-1:0] out_product;
  logic             busy;

  // Transfers complete on a rising edge where valid and ready are both high.
  // A valid source holds its payload until that edge.
  modport master (
    output flush, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  flush, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/mul_shift_add_ctrl.sv
// Multi-cycle unsigned shift-add multiplier: one add/shift iteration per clock,
// a fixed LEN iterations per operation, result held until the consumer takes it.
module mul_shift_add_ctrl #(
  parameter int LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_shift_add_ctrl_if.slave  bus,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2*LEN-1:0] acc_q;
  logic [2*LEN-1:0] acc_d;
  logic [2*LEN-1:0] mcand_q;
  logic [LEN-1:0]   mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [2*LEN-1:0] out_product_q;
  logic             out_valid_q;
  logic             busy_q;

  // The product of two LEN-bit operands always fits in 2*LEN bits, so the add never wraps.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc_q         <= '0;
            out_product_q <= '0;
            mcand_q       <= {{LEN{1'b0}}, bus.in_a};
            mplier_q      <= bus.in_b;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            state_q       <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q         <= acc_d;
          out_product_q <= acc_d;
          mcand_q       <= mcand_q << 1;
          mplier_q      <= mplier_q >> 1;
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // Flush blocks acceptance in the same cycle so it always wins over in_valid.
  assign bus.in_ready    = (state_q == S_IDLE) && !bus.flush;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mul_shift_add_ctrl.sv
// Bench for the shift-add multiplier: vector table, hand-written corner sequences,
// and randomized operations checked against a plain a*b reference.
module tb_mul_shift_add_ctrl;

  logic clk;
  logic rst_n;

  mul_shift_add_ctrl_if #(.LEN(32)) bus ();
  mul_shift_add_ctrl_if #(.LEN(8))  bus8 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state8;

  mul_shift_add_ctrl #(.LEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  mul_shift_add_ctrl #(.LEN(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus8.slave),
    .dbg_state_o (dbg_state8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks (all driving and sampling on the falling edge)
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(64'(a) * 64'(b));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom();
    bus.in_b     = $urandom();
  endtask

  task automatic wait_result(output logic [63:0] prod);
    int n;
    logic seen;
    logic [63:0] exp;
    seen = 1'b0;
    prod = '0;
    for (n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.in_ready) check("in_ready_while_busy", 64'd1, 64'd0);
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      check("result_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(n), 64'd32);
      check("product", bus.out_product, exp);
      check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
      check("busy_in_done", 64'(bus.busy), 64'd1);
      prod = bus.out_product;
    end
  endtask

  task automatic finish_op(input int stall);
    logic [63:0] held;
    held = bus.out_product;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_product", bus.out_product, held);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_busy", 64'(bus.busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] prod;
    int highs;
    int n8;
    logic seen8;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          stall: 0, exp: 64'd15};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  stall: 0, exp: 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{a: 32'd0,          b: 32'd1234,       stall: 0, exp: 64'd0};
    vecs[3] = '{a: 32'h0000_ABCD,  b: 32'd0,          stall: 1, exp: 64'd0};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          stall: 5, exp: 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{a: 32'h8000_0000,  b: 32'd2,          stall: 2, exp: 64'h0000_0001_0000_0000};

    rst_n = 1'b0;
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.out_ready = 1'b0;
    bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_product", bus.out_product, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // vector table
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(prod);
      check("table_product", prod, vecs[i].exp);
      finish_op(vecs[i].stall);
    end

    // flush during IDLE wins over in_valid
    @(negedge clk);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 32'd4;
    bus.in_b = 32'd4;
    #1 check("flush_blocks_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_no_accept", 64'(bus.busy), 64'd0);

    // flush after ten iterations, no result afterwards
    start_op(32'd9, 32'd9);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy", 64'(bus.busy), 64'd0);
    check("flush_state", 64'(dbg_state), 64'd0);
    highs = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) highs++;
    end
    check("flush_no_valid_pulse", 64'(highs), 64'd0);
    start_op(32'd7, 32'd6);
    wait_result(prod);
    check("after_flush_product", prod, 64'd42);
    finish_op(0);

    // flush together with out_ready in DONE
    start_op(32'd11, 32'd13);
    wait_result(prod);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    check("done_flush_valid", 64'(bus.out_valid), 64'd0);
    check("done_flush_state", 64'(dbg_state), 64'd0);

    // asynchronous reset mid-BUSY
    start_op(32'd1, 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy_product", bus.out_product, 64'd0);
    check("rst_busy_busy", 64'(bus.busy), 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in DONE
    start_op(32'd5, 32'd5);
    wait_result(prod);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done_product", bus.out_product, 64'd0);
    check("rst_done_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd12, 32'd12);
    wait_result(prod);
    finish_op(0);

    // randomized operations against the a*b reference
    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'(($urandom_range(0, 15)));
        default: ;
      endcase
      start_op(ra, rb);
      wait_result(prod);
      finish_op($urandom_range(0, 3));
    end

    // LEN=8 instance
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_a = 8'hFF;
    bus8.in_b = 8'h80;
    check("len8_in_ready", 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    seen8 = 1'b0;
    for (n8 = 1; n8 <= 30; n8++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus8.out_valid) begin
        seen8 = 1'b1;
        break;
      end
    end
    check("len8_seen", 64'(seen8), 64'd1);
    check("len8_latency", 64'(n8), 64'd8);
    check("len8_product", 64'(bus8.out_product), 64'h7F80);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    check("len8_idle_valid", 64'(bus8.out_valid), 64'd0);
    check("len8_idle_in_ready", 64'(bus8.in_ready), 64'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
